// File: rtl/aes_dec_pkg.sv
// Shared definitions for the iterative AES inverse cipher: FSM state
// encoding, the inverse S-box and the GF(2^8) constant multipliers that
// InvMixColumns needs. All field arithmetic reduces modulo x^8+x^4+x^3+x+1.
package aes_dec_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fsmState_t;

  // Inverse S-box, entry 0x00 in the top byte, entry 0xff in the bottom byte.
  localparam logic [2047:0] INV_SBOX_FLAT = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] invSubByte(input logic [7:0] b);
    return INV_SBOX_FLAT[(11'd2047 - {b, 3'b000}) -: 8];
  endfunction

  // Multiply by {02}, folding the carry back with the reduction polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gfMul09(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction

  function automatic logic [7:0] gfMul0b(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction

  function automatic logic [7:0] gfMul0d(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction

  function automatic logic [7:0] gfMul0e(input logic [7:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

endpackage

// File: rtl/aes_inv_round_comb.sv
// One inverse AES round, purely combinational:
// InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns (bypassed on
// the final round via skip_mix). Byte k of the state sits at bits
// [127-8k -: 8], with k = row + 4*column.
module aes_inv_round_comb
  import aes_dec_pkg::*;
(
  input  logic [127:0] stateIn,
  input  logic [127:0] roundKey,
  input  logic         skip_mix,
  output logic [127:0] stateOut
);

  logic [127:0] keyed;
  logic [127:0] mixed;

  // Row r rotates right by r columns; each byte then goes through the
  // inverse S-box and is XORed with the matching round-key byte.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    keyed = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        keyed[127 - 8*(r + 4*c) -: 8] =
          invSubByte(stateIn[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8]) ^
          roundKey[127 - 8*(r + 4*c) -: 8];
      end
    end
  end

  // InvMixColumns: each column times the circulant {0e,0b,0d,09} matrix.
  always_comb begin
    logic [7:0] a0, a1, a2, a3;
    mixed = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = keyed[127 - 32*c -: 8];
      a1 = keyed[119 - 32*c -: 8];
      a2 = keyed[111 - 32*c -: 8];
      a3 = keyed[103 - 32*c -: 8];
      mixed[127 - 32*c -: 8] = gfMul0e(a0) ^ gfMul0b(a1) ^ gfMul0d(a2) ^ gfMul09(a3);
      mixed[119 - 32*c -: 8] = gfMul09(a0) ^ gfMul0e(a1) ^ gfMul0b(a2) ^ gfMul0d(a3);
      mixed[111 - 32*c -: 8] = gfMul0d(a0) ^ gfMul09(a1) ^ gfMul0e(a2) ^ gfMul0b(a3);
      mixed[103 - 32*c -: 8] = gfMul0b(a0) ^ gfMul0d(a1) ^ gfMul09(a2) ^ gfMul0e(a3);
    end
  end

  assign stateOut = skip_mix ? keyed : mixed;

endmodule

// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher: one round per clock, round keys fetched
// from an external schedule through rk_idx/rk_in in the same cycle.
// A block accepted in cycle k is presented on pt_out with out_valid in
// cycle k+NR+1; a DONE cycle with out_ready=1 can accept the next block.
module aes_inv_cipher_iter
  import aes_dec_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] ct_in,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_in,
  output logic [127:0] pt_out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  if (!(NR == 10 || NR == 12 || NR == 14)) begin : gBadNr
    $error("aes_inv_cipher_iter: NR must be 10, 12 or 14");
  end

  localparam logic [3:0] NR_IDX     = 4'(NR);
  localparam logic [3:0] LAST_ROUND = 4'(NR - 1);

  fsmState_t    stateQ;
  fsmState_t    nextState;
  logic [3:0]   roundQ;
  logic [127:0] stateReg;
  logic [127:0] ptReg;
  logic [127:0] roundResult;
  logic         acceptOk;
  logic         loadNew;
  logic [3:0]   rkSel;

  aes_inv_round_comb uRound (
    .stateIn  (stateReg),
    .roundKey (rk_in),
    .skip_mix (roundQ == 4'd0),
    .stateOut (roundResult)
  );

  // Next-state, acceptance and round-key index; rk index depends only on
  // FSM state and round so the key source never sees a combinational loop.
  always_comb begin
    nextState = stateQ;
    acceptOk  = 1'b0;
    rkSel     = NR_IDX;
    unique case (stateQ)
      IDLE: acceptOk = 1'b1;
      RUN: begin
        rkSel = roundQ;
        if (roundQ == 4'd0) nextState = DONE;
      end
      DONE: begin
        if (out_ready) begin
          acceptOk  = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    loadNew = acceptOk & in_valid;
    if (loadNew) nextState = RUN;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) stateQ <= IDLE;
    else     stateQ <= nextState;
  end

  // Datapath: initial AddRoundKey on accept, one inverse round per RUN
  // cycle, final round lands in the output register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (rst) begin
      roundQ   <= '0;
      stateReg <= '0;
      ptReg    <= '0;
    end else if (loadNew) begin
      stateReg <= ct_in ^ rk_in;
      roundQ   <= LAST_ROUND;
    end else if (stateQ == RUN) begin
      if (roundQ != 4'd0) begin
        stateReg <= roundResult;
        roundQ   <= roundQ - 4'd1;
      end else begin
        ptReg <= roundResult;
      end
    end
  end

  assign in_ready  = acceptOk & ~rst;
  assign rk_idx    = rkSel;
  assign pt_out    = ptReg;
  assign out_valid = (stateQ == DONE);
  assign busy      = (stateQ != IDLE);

endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: one instance per legal NR (10, 12, 14).
// Round keys come from a table per instance, indexed by rk_idx. Expected
// plaintext comes from a byte-array AES inverse cipher whose S-box is
// derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_cipher_iter;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ctIn;
  logic         inValid  [3];
  logic         outReady [3];
  logic         inReady  [3];
  logic         outValid [3];
  logic         busyO    [3];
  logic [3:0]   rkIdx    [3];
  logic [127:0] rkIn     [3];
  logic [127:0] ptOut    [3];
  logic [127:0] rkTab    [3][16];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int sbox  [256];
  int invSb [256];
  int rkSeq [$];

  localparam logic [127:0] KAT_PT = 128'h00112233445566778899aabbccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : gDut
    aes_inv_cipher_iter #(.NR(10 + 2*g)) dut (
      .clk       (clk),
      .rst       (rst),
      .ct_in     (ctIn),
      .in_valid  (inValid[g]),
      .in_ready  (inReady[g]),
      .rk_idx    (rkIdx[g]),
      .rk_in     (rkIn[g]),
      .pt_out    (ptOut[g]),
      .out_valid (outValid[g]),
      .out_ready (outReady[g]),
      .busy      (busyO[g])
    );
    assign rkIn[g] = rkTab[g][rkIdx[g]];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int gmul(input int a, input int b);
    int p = 0;
    int x;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (((b >> i) & 1) != 0) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11b;
    end
    return p & 'hff;
  endfunction

  function automatic int rotl8(input int v, input int n);
    return ((v << n) | (v >> (8 - n))) & 'hff;
  endfunction

  task automatic buildSbox();
    int inv;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++) if (x != 0 && gmul(x, y) == 1) inv = y;
      sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 'h63;
    end
    for (int x = 0; x < 256; x++) invSb[sbox[x]] = x;
  endtask

  function automatic int unsigned subWord(input int unsigned w);
    return (int'(sbox[(w >> 24) & 255]) << 24) | (int'(sbox[(w >> 16) & 255]) << 16) |
           (int'(sbox[(w >> 8) & 255]) << 8) | int'(sbox[w & 255]);
  endfunction

  // FIPS-197 key expansion for key bytes 00,01,02,... of length 4*Nk.
  task automatic expandKey(input int sel);
    int nr, nk;
    int unsigned w [60];
    int unsigned t, rcon;
    nr = 10 + 2*sel;
    nk = nr - 6;
    rcon = 1;
    for (int i = 0; i < nk; i++)
      w[i] = ((4*i) << 24) | ((4*i + 1) << 16) | ((4*i + 2) << 8) | (4*i + 3);
    for (int i = nk; i < 4*(nr + 1); i++) begin
      t = w[i - 1];
      if (i % nk == 0) begin
        t = (t << 8) | (t >> 24);
        t = subWord(t) ^ (rcon << 24);
        rcon = gmul(rcon, 2);
      end else if (nk > 6 && i % nk == 4) begin
        t = subWord(t);
      end
      w[i] = w[i - nk] ^ t;
    end
    for (int r = 0; r <= nr; r++) rkTab[sel][r] = {w[4*r], w[4*r + 1], w[4*r + 2], w[4*r + 3]};
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic randomizeKeys(input int sel);
    for (int r = 0; r < 16; r++) rkTab[sel][r] = rand128();
  endtask

  // Textbook inverse cipher on a 16-byte array (column-major).
  function automatic logic [127:0] refDecrypt(input int sel, input logic [127:0] ct);
    int nr, acc;
    int s [16];
    int t [16];
    int base [4] = '{14, 11, 13, 9};
    logic [127:0] k, res;
    nr = 10 + 2*sel;
    k = rkTab[sel][nr];
    for (int i = 0; i < 16; i++) s[i] = int'(ct[127 - 8*i -: 8] ^ k[127 - 8*i -: 8]);
    for (int r = nr - 1; r >= 0; r--) begin
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) t[row + 4*c] = s[row + 4*((c - row + 4) % 4)];
      k = rkTab[sel][r];
      for (int i = 0; i < 16; i++) s[i] = invSb[t[i]] ^ int'(k[127 - 8*i -: 8]);
      if (r > 0) begin
        for (int c = 0; c < 4; c++)
          for (int row = 0; row < 4; row++) begin
            acc = 0;
            for (int j = 0; j < 4; j++) acc = acc ^ gmul(base[(j - row + 4) % 4], s[j + 4*c]);
            t[row + 4*c] = acc;
          end
        s = t;
      end
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = s[i][7:0];
    return res;
  endfunction

  // Offer one block at a negedge and run until out_valid (bounded). Returns
  // at the negedge of the first DONE cycle; out_ready is left untouched.
  task automatic doBlock(input int sel, input logic [127:0] ct, output logic [127:0] pt,
                         output int lat, output bit timedOut);
    int acc, n;
    timedOut = 1'b0;
    lat = -1;
    pt = '0;
    rkSeq.delete();
    ctIn = ct;
    inValid[sel] = 1'b1;
    n = 0;
    while (!inReady[sel] && n < 50) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    rkSeq.push_back(int'(rkIdx[sel]));
    @(negedge clk);
    inValid[sel] = 1'b0;
    n = 0;
    while (!outValid[sel] && n < 40) begin
      rkSeq.push_back(int'(rkIdx[sel]));
      @(negedge clk);
      n++;
    end
    timedOut = !outValid[sel];
    lat = cyc - acc;
    pt = ptOut[sel];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total++; if (inReady[g] !== 1'b0) begin bad++; $display("FAIL rst_in_ready[%0d]: got %b want 0", g, inReady[g]); end
      total++; if (outValid[g] !== 1'b0) begin bad++; $display("FAIL rst_out_valid[%0d]: got %b want 0", g, outValid[g]); end
      total++; if (busyO[g] !== 1'b0) begin bad++; $display("FAIL rst_busy[%0d]: got %b want 0", g, busyO[g]); end
      total++; if (ptOut[g] !== 128'h0) begin bad++; $display("FAIL rst_pt_out[%0d]: got %h want 0", g, ptOut[g]); end
    end
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      total++; if (inReady[g] !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready[%0d]: got %b want 1", g, inReady[g]); end
      total++; if (rkIdx[g] !== 4'(10 + 2*g)) begin bad++; $display("FAIL post_rst_rk_idx[%0d]: got %0d want %0d", g, rkIdx[g], 10 + 2*g); end
    end
  endtask

  task automatic test_kat();
    logic [127:0] kct [3];
    logic [127:0] pt;
    int lat, nr;
    bit to, seqOk;
    kct[0] = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    kct[1] = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
    kct[2] = 128'h8ea2b7ca516745bfeafc49904b496089;
    for (int g = 0; g < 3; g++) begin
      nr = 10 + 2*g;
      expandKey(g);
      doBlock(g, kct[g], pt, lat, to);
      total++; if (to) begin bad++; $display("FAIL kat_timeout[%0d]: out_valid never rose", nr); end
      total++; if (pt !== KAT_PT) begin bad++; $display("FAIL kat_pt[%0d]: got %h want %h", nr, pt, KAT_PT); end
      total++; if (lat !== nr + 1) begin bad++; $display("FAIL kat_latency[%0d]: got %0d want %0d", nr, lat, nr + 1); end
      seqOk = (rkSeq.size() == nr + 1);
      for (int i = 0; i < rkSeq.size() && i <= nr; i++) if (rkSeq[i] != nr - i) seqOk = 1'b0;
      total++; if (!seqOk) begin bad++; $display("FAIL kat_rk_seq[%0d]: got %p want %0d down to 0", nr, rkSeq, nr); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall();
    logic [127:0] ct, exp, pt;
    int lat;
    bit to;
    randomizeKeys(0);
    ct = rand128();
    exp = refDecrypt(0, ct);
    outReady[0] = 1'b0;
    doBlock(0, ct, pt, lat, to);
    total++; if (to) begin bad++; $display("FAIL stall_timeout: out_valid never rose"); end
    ctIn = rand128();
    inValid[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (ptOut[0] !== exp) begin bad++; $display("FAIL stall_pt[%0d]: got %h want %h", i, ptOut[0], exp); end
      total++; if (outValid[0] !== 1'b1) begin bad++; $display("FAIL stall_out_valid[%0d]: got %b want 1", i, outValid[0]); end
      total++; if (inReady[0] !== 1'b0) begin bad++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, inReady[0]); end
      @(negedge clk);
    end
    inValid[0] = 1'b0;
    outReady[0] = 1'b1;
    @(negedge clk);
    total++; if (busyO[0] !== 1'b0) begin bad++; $display("FAIL stall_no_second_block: busy got %b want 0", busyO[0]); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] cts [3];
    logic [127:0] exps [3];
    logic [127:0] outPt [3];
    int outCyc [3];
    int sels [2] = '{0, 2};
    int sel, nr, nAcc, nOut;
    for (int s = 0; s < 2; s++) begin
      sel = sels[s];
      nr = 10 + 2*sel;
      randomizeKeys(sel);
      for (int b = 0; b < 3; b++) begin
        cts[b] = rand128();
        exps[b] = refDecrypt(sel, cts[b]);
        outCyc[b] = 0;
        outPt[b] = '0;
      end
      outReady[sel] = 1'b1;
      nAcc = 0;
      nOut = 0;
      for (int n = 0; n < 3*(nr + 1) + 20 && nOut < 3; n++) begin
        if (nAcc < 3) begin
          ctIn = cts[nAcc];
          inValid[sel] = 1'b1;
        end else begin
          inValid[sel] = 1'b0;
        end
        if (outValid[sel]) begin
          outCyc[nOut] = cyc;
          outPt[nOut] = ptOut[sel];
          nOut++;
        end
        if (inValid[sel] && inReady[sel]) nAcc++;
        @(negedge clk);
      end
      inValid[sel] = 1'b0;
      total++; if (nOut !== 3) begin bad++; $display("FAIL b2b_count[%0d]: got %0d outputs want 3", nr, nOut); end
      for (int b = 0; b < 3; b++) begin
        total++; if (outPt[b] !== exps[b]) begin bad++; $display("FAIL b2b_pt[%0d][%0d]: got %h want %h", nr, b, outPt[b], exps[b]); end
      end
      for (int b = 1; b < 3; b++) begin
        total++; if (outCyc[b] - outCyc[b - 1] !== nr + 1) begin bad++; $display("FAIL b2b_spacing[%0d][%0d]: got %0d want %0d", nr, b, outCyc[b] - outCyc[b - 1], nr + 1); end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [127:0] ct, exp, pt;
    int n, lat;
    bit sawOut, to;
    randomizeKeys(1);
    ct = rand128();
    ctIn = ct;
    inValid[1] = 1'b1;
    @(negedge clk);
    inValid[1] = 1'b0;
    n = 0;
    sawOut = 1'b0;
    while (rkIdx[1] !== 4'd4 && n < 30) begin
      if (outValid[1]) sawOut = 1'b1;
      @(negedge clk);
      n++;
    end
    total++; if (rkIdx[1] !== 4'd4 || busyO[1] !== 1'b1) begin bad++; $display("FAIL midrun_reach_round4: rk_idx got %0d busy %b want 4 and 1", rkIdx[1], busyO[1]); end
    rst = 1'b1;
    @(negedge clk);
    total++; if (busyO[1] !== 1'b0) begin bad++; $display("FAIL midrun_rst_busy: got %b want 0", busyO[1]); end
    total++; if (inReady[1] !== 1'b0) begin bad++; $display("FAIL midrun_rst_in_ready: got %b want 0", inReady[1]); end
    total++; if (ptOut[1] !== 128'h0) begin bad++; $display("FAIL midrun_rst_pt: got %h want 0", ptOut[1]); end
    rst = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (outValid[1]) sawOut = 1'b1;
    end
    total++; if (sawOut) begin bad++; $display("FAIL midrun_aborted_output: out_valid got 1 want 0"); end
    ct = rand128();
    exp = refDecrypt(1, ct);
    doBlock(1, ct, pt, lat, to);
    total++; if (to || pt !== exp) begin bad++; $display("FAIL midrun_next_pt: got %h want %h", pt, exp); end
    total++; if (lat !== 13) begin bad++; $display("FAIL midrun_next_latency: got %0d want 13", lat); end
    @(negedge clk);
  endtask

  task automatic test_ignore();
    logic [127:0] ct1, exp;
    int acc, n;
    randomizeKeys(2);
    ct1 = rand128();
    exp = refDecrypt(2, ct1);
    ctIn = ct1;
    inValid[2] = 1'b1;
    acc = cyc;
    @(negedge clk);
    ctIn = rand128();
    for (int i = 0; i < 5; i++) begin
      total++; if (inReady[2] !== 1'b0) begin bad++; $display("FAIL ignore_in_ready[%0d]: got %b want 0", i, inReady[2]); end
      @(negedge clk);
    end
    inValid[2] = 1'b0;
    n = 0;
    while (!outValid[2] && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++; if (ptOut[2] !== exp || outValid[2] !== 1'b1) begin bad++; $display("FAIL ignore_pt: got %h valid %b want %h", ptOut[2], outValid[2], exp); end
    total++; if (cyc - acc !== 15) begin bad++; $display("FAIL ignore_latency: got %0d want 15", cyc - acc); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [127:0] ct, exp, pt;
    int sel, nr, lat, dly;
    bit to;
    for (int it = 0; it < 6; it++) begin
      sel = $urandom_range(0, 2);
      nr = 10 + 2*sel;
      randomizeKeys(sel);
      ct = rand128();
      exp = refDecrypt(sel, ct);
      dly = $urandom_range(0, 3);
      outReady[sel] = (dly == 0);
      doBlock(sel, ct, pt, lat, to);
      total++; if (to || pt !== exp) begin bad++; $display("FAIL rand_pt[%0d] nr=%0d: got %h want %h", it, nr, pt, exp); end
      total++; if (lat !== nr + 1) begin bad++; $display("FAIL rand_latency[%0d] nr=%0d: got %0d want %0d", it, nr, lat, nr + 1); end
      for (int i = 0; i < dly; i++) begin
        @(negedge clk);
        total++; if ({ptOut[sel], outValid[sel]} !== {exp, 1'b1}) begin bad++; $display("FAIL rand_hold[%0d][%0d]: got %h/%b want %h/1", it, i, ptOut[sel], outValid[sel], exp); end
      end
      outReady[sel] = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    ctIn = '0;
    for (int g = 0; g < 3; g++) begin
      inValid[g] = 1'b0;
      outReady[g] = 1'b1;
      for (int r = 0; r < 16; r++) rkTab[g][r] = '0;
    end
    buildSbox();
    test_reset();
    test_kat();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_ignore();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
